// File: rtl/memristor_bank_if.sv
// Command/response handshake bundle for memristor_bank.
// master drives commands and accepts responses; slave is the bank.
interface memristor_bank_if #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned VIN_W   = 8,
  parameter int unsigned G_W     = 32,
  parameter int unsigned PULSE_W = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_W-1:0]         cmd_addr;
  logic signed [VIN_W-1:0]   cmd_vin;
  logic [PULSE_W-1:0]        cmd_pulses;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [G_W-1:0]            rsp_g;
  logic                      rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_vin, cmd_pulses, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_g, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_vin, cmd_pulses, rsp_ready,
    output cmd_ready, rsp_valid, rsp_g, rsp_err
  );
endinterface

// File: rtl/memristor_bank.sv
// Bank of NUM_CELLS memristor conductance emulators behind a valid/ready
// command port. Cells are seeded at reset with G_INIT plus LFSR mismatch.
// Optional feature macro: MEMRISTOR_WINDOW_EN (halves SET/RESET steps near
// the conductance rails).
module memristor_bank #(
  parameter int unsigned NUM_CELLS     = 4,
  parameter int unsigned ADDR_W        = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1,
  parameter int unsigned VIN_W         = 8,
  parameter int unsigned G_W           = 32,
  parameter int unsigned PULSE_W       = 8,
  parameter int unsigned G_MIN         = 1000,
  parameter int unsigned G_MAX         = 100000,
  parameter int unsigned G_INIT        = 10000,
  parameter int unsigned VTH_POS       = 1,
  parameter int unsigned VTH_NEG       = 1,
  parameter int unsigned K_UP          = 100,
  parameter int unsigned K_DN          = 100,
  parameter int unsigned MISMATCH_BITS = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  memristor_bank_if.slave    bus,
  output logic               busy
);

  localparam int unsigned IdxW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int unsigned EW   = G_W + VIN_W + 1;
  localparam logic [15:0] MisMask = 16'((32'd1 << MISMATCH_BITS) - 32'd1);

  localparam logic signed [EW-1:0] VthPosE = EW'(VTH_POS);
  localparam logic signed [EW-1:0] VthNegE = EW'(VTH_NEG);
  localparam logic signed [EW-1:0] KUpE    = EW'(K_UP);
  localparam logic signed [EW-1:0] KDnE    = EW'(K_DN);
  localparam logic signed [EW-1:0] GMinE   = EW'(G_MIN);
  localparam logic signed [EW-1:0] GMaxE   = EW'(G_MAX);
`ifdef MEMRISTOR_WINDOW_EN
  localparam int unsigned          Quarter = (G_MAX - G_MIN) / 4;
  localparam logic signed [EW-1:0] WinHiE  = EW'(G_MAX - Quarter);
  localparam logic signed [EW-1:0] WinLoE  = EW'(G_MIN + Quarter);
`endif

  typedef enum logic [1:0] {StInit, StIdle, StApply, StResp} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         init_idx_q, init_idx_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [IdxW-1:0]         addr_q, addr_d;
  logic signed [VIN_W-1:0] vin_q, vin_d;
  logic [PULSE_W-1:0]      pulses_q, pulses_d;
  logic [G_W-1:0]          rsp_g_q, rsp_g_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [G_W-1:0]          cells_q [NUM_CELLS];
  logic [G_W-1:0]          cells_d [NUM_CELLS];

  logic                    cmd_in_range;
  logic [IdxW-1:0]         cmd_idx;
  logic [15:0]             lfsr_next;
  logic signed [EW-1:0]    g_ext, v_ext, step, g_upd_ext;
  logic [G_W-1:0]          g_upd;

  assign cmd_in_range = 32'(bus.cmd_addr) < NUM_CELLS;
  assign cmd_idx      = IdxW'(bus.cmd_addr);
  // Galois right-shift form of x^16+x^14+x^13+x^11
  assign lfsr_next    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // One conductance step of the latched cell, computed wide so clamping never sees a wrap
  always_comb begin
    g_ext     = EW'(cells_q[addr_q]);
    v_ext     = EW'(vin_q);
    step      = '0;
    g_upd_ext = g_ext;
    if (v_ext > VthPosE) begin
      step = (v_ext - VthPosE) * KUpE;
`ifdef MEMRISTOR_WINDOW_EN
      if (g_ext >= WinHiE) step = step >>> 1;
`endif
      g_upd_ext = g_ext + step;
      if (g_upd_ext > GMaxE) g_upd_ext = GMaxE;
    end else if (v_ext < -VthNegE) begin
      step = (-v_ext - VthNegE) * KDnE;
`ifdef MEMRISTOR_WINDOW_EN
      if (g_ext <= WinLoE) step = step >>> 1;
`endif
      g_upd_ext = g_ext - step;
      if (g_upd_ext < GMinE) g_upd_ext = GMinE;
    end
    g_upd = G_W'(g_upd_ext);
  end

  // Next-state logic: cell initialisation, command accept, pulse application, response hold
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    lfsr_d     = lfsr_q;
    addr_d     = addr_q;
    vin_d      = vin_q;
    pulses_d   = pulses_q;
    rsp_g_d    = rsp_g_q;
    rsp_err_d  = rsp_err_q;
    cells_d    = cells_q;
    unique case (state_q)
      StInit: begin
        cells_d[init_idx_q] = G_W'(G_INIT) + G_W'(lfsr_q & MisMask);
        lfsr_d = lfsr_next;
        if (init_idx_q == IdxW'(NUM_CELLS - 1)) begin
          state_d = StIdle;
        end else begin
          init_idx_d = IdxW'(init_idx_q + 1'b1);
        end
      end
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d   = cmd_idx;
          vin_d    = bus.cmd_vin;
          pulses_d = bus.cmd_pulses;
          if (!cmd_in_range) begin
            rsp_g_d   = '0;
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else if (bus.cmd_pulses == '0) begin
            rsp_g_d   = cells_q[cmd_idx];
            rsp_err_d = 1'b0;
            state_d   = StResp;
          end else begin
            state_d = StApply;
          end
        end
      end
      StApply: begin
        cells_d[addr_q] = g_upd;
        pulses_d        = pulses_q - PULSE_W'(1);
        if (pulses_q == PULSE_W'(1)) begin
          rsp_g_d   = g_upd;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // State registers; reset restarts initialisation and drops any in-flight response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      lfsr_q     <= SEED;
      addr_q     <= '0;
      vin_q      <= '0;
      pulses_q   <= '0;
      rsp_g_q    <= '0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_CELLS); i++) cells_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      lfsr_q     <= lfsr_d;
      addr_q     <= addr_d;
      vin_q      <= vin_d;
      pulses_q   <= pulses_d;
      rsp_g_q    <= rsp_g_d;
      rsp_err_q  <= rsp_err_d;
      cells_q    <= cells_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_g     = rsp_g_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_memristor_bank.sv
// Self-checking bench for memristor_bank: dut_a (no mismatch, 3-bit address)
// carries the functional tests, dut_b (default mismatch) the LFSR seeding.
module tb_memristor_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memristor_bank_if #(.ADDR_W(3)) bus_a ();
  memristor_bank_if #(.ADDR_W(2)) bus_b ();
  logic busy_a, busy_b;

  memristor_bank #(.NUM_CELLS(4), .ADDR_W(3), .MISMATCH_BITS(0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a),
    .busy (busy_a)
  );

  memristor_bank dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b),
    .busy (busy_b)
  );

  typedef struct {
    longint g;
    logic   err;
    int     lat;
  } exp_t;

  exp_t   sb[$];
  int     nvec = 0;
  int     nerr = 0;
  longint model[4];
  longint obs_g;
  logic   obs_err;
  int     obs_lat;

  // Reference step of the conductance rule, in wide integer arithmetic
  function automatic longint step_model(input longint g, input int v);
    longint s;
    longint r;
    r = g;
    if (v > 1) begin
      s = longint'(v - 1) * 100;
`ifdef MEMRISTOR_WINDOW_EN
      if (g >= 75250) s = s / 2;
`endif
      r = g + s;
      if (r > 100000) r = 100000;
    end else if (v < -1) begin
      s = longint'(-v - 1) * 100;
`ifdef MEMRISTOR_WINDOW_EN
      if (g <= 25750) s = s / 2;
`endif
      r = g - s;
      if (r < 1000) r = 1000;
    end
    return r;
  endfunction

  // Issue one command on bus_a, predict its response, then capture the DUT response
  task automatic run_cmd(input int a, input int v, input int p);
    exp_t e;
    int   n;
    longint g;
    @(negedge clk);
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_addr   = 3'(a);
    bus_a.cmd_vin    = 8'(v);
    bus_a.cmd_pulses = 8'(p);
    n = 0;
    while (!bus_a.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.cmd_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout addr=%0d: cmd_ready stayed 0, required 1", a);
      bus_a.cmd_valid = 1'b0;
      return;
    end
    if (a >= 4) begin
      e.g = 0; e.err = 1'b1; e.lat = 1;
    end else begin
      g = model[a];
      for (int i = 0; i < p; i++) g = step_model(g, v);
      model[a] = g;
      e.g = g; e.err = 1'b0; e.lat = p + 1;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    obs_lat = 1;
    while (!bus_a.rsp_valid && obs_lat < 1000) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_g   = longint'(bus_a.rsp_g);
    obs_err = bus_a.rsp_err;
    if (!bus_a.rsp_valid) begin
      nvec++;
      nerr++;
      $display("FAIL rsp_timeout addr=%0d: rsp_valid stayed 0, required 1", a);
    end
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    nvec++;
    if (bus_a.cmd_ready !== 1'b0 || bus_a.rsp_valid !== 1'b0 || bus_a.rsp_g !== 32'd0 ||
        bus_a.rsp_err !== 1'b0 || busy_a !== 1'b1) begin
      nerr++;
      $display("FAIL reset_values: rdy=%b vld=%b g=%0d err=%b busy=%b, required 0 0 0 0 1",
               bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_g, bus_a.rsp_err, busy_a);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (busy_a !== 1'b1 || bus_a.cmd_ready !== 1'b0) begin
      nerr++;
      $display("FAIL init_running: busy=%b rdy=%b after 3 cycles, required 1 0",
               busy_a, bus_a.cmd_ready);
    end
    @(negedge clk);
    nvec++;
    if (busy_a !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL init_done: busy=%b rdy=%b after 4 cycles, required 0 1",
               busy_a, bus_a.cmd_ready);
    end
    for (int i = 0; i < 4; i++) model[i] = 10000;
  endtask

  task automatic test_read();
    exp_t e;
    run_cmd(0, 0, 0);
    e = sb.pop_front();
    nvec++;
    if (obs_g !== e.g || obs_g !== 64'd10000 || obs_err !== 1'b0 || obs_lat !== 1) begin
      nerr++;
      $display("FAIL read_cell0: g=%0d err=%b lat=%0d, required g=10000 err=0 lat=1",
               obs_g, obs_err, obs_lat);
    end
  endtask

  task automatic test_set_reset();
    int vs[4] = '{4, -4, 1, -1};
    int ps[4] = '{3, 2, 5, 5};
`ifdef MEMRISTOR_WINDOW_EN
    longint lit[4] = '{10900, 10600, 10600, 10600};
`else
    longint lit[4] = '{10900, 10300, 10300, 10300};
`endif
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_cmd(1, vs[i], ps[i]);
      e = sb.pop_front();
      nvec++;
      if (obs_g !== e.g || obs_g !== lit[i] || obs_err !== e.err || obs_lat !== e.lat) begin
        nerr++;
        $display("FAIL set_reset[%0d]: g=%0d err=%b lat=%0d, required g=%0d err=%b lat=%0d",
                 i, obs_g, obs_err, obs_lat, lit[i], e.err, e.lat);
      end
    end
  endtask

  task automatic test_saturation();
    int     vs[2]  = '{127, -128};
    int     ps[2]  = '{10, 200};
    longint lit[2] = '{100000, 1000};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_cmd(2, vs[i], ps[i]);
      e = sb.pop_front();
      nvec++;
      if (obs_g !== e.g || obs_g !== lit[i] || obs_err !== 1'b0 || obs_lat !== e.lat) begin
        nerr++;
        $display("FAIL saturation[%0d]: g=%0d err=%b lat=%0d, required g=%0d err=0 lat=%0d",
                 i, obs_g, obs_err, obs_lat, lit[i], e.lat);
      end
    end
  endtask

  task automatic test_addressing();
    exp_t e;
    run_cmd(5, 4, 3);
    e = sb.pop_front();
    nvec++;
    if (obs_g !== 64'd0 || obs_err !== 1'b1 || obs_lat !== 1) begin
      nerr++;
      $display("FAIL bad_addr: g=%0d err=%b lat=%0d, required g=0 err=1 lat=1",
               obs_g, obs_err, obs_lat);
    end
    for (int i = 0; i < 4; i++) begin
      run_cmd(i, 0, 0);
      e = sb.pop_front();
      nvec++;
      if (obs_g !== e.g || obs_err !== 1'b0) begin
        nerr++;
        $display("FAIL readback[%0d]: g=%0d err=%b, required g=%0d err=0",
                 i, obs_g, obs_err, e.g);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [15:0] l;
    longint      want;
    l = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      want = 10000 + longint'(l & 16'h000F);
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      @(negedge clk);
      bus_b.cmd_valid  = 1'b1;
      bus_b.cmd_addr   = 2'(i);
      bus_b.cmd_vin    = 8'd0;
      bus_b.cmd_pulses = 8'd0;
      nvec++;
      if (bus_b.cmd_ready !== 1'b1) begin
        nerr++;
        $display("FAIL mismatch_ready[%0d]: cmd_ready=%b, required 1", i, bus_b.cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus_b.cmd_valid = 1'b0;
      nvec++;
      if (bus_b.rsp_valid !== 1'b1 || longint'(bus_b.rsp_g) !== want || bus_b.rsp_err !== 1'b0)
      begin
        nerr++;
        $display("FAIL mismatch[%0d]: vld=%b g=%0d err=%b, required vld=1 g=%0d err=0",
                 i, bus_b.rsp_valid, bus_b.rsp_g, bus_b.rsp_err, want);
      end
      bus_b.rsp_ready = 1'b1;
      @(negedge clk);
      bus_b.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    @(negedge clk);
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_addr   = 3'd1;
    bus_a.cmd_vin    = 8'd0;
    bus_a.cmd_pulses = 8'd0;
    @(posedge clk);
    @(negedge clk);
    // A different command stays offered while the response is stalled
    bus_a.cmd_addr   = 3'd2;
    bus_a.cmd_vin    = 8'd50;
    bus_a.cmd_pulses = 8'd1;
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (bus_a.rsp_valid !== 1'b1 || longint'(bus_a.rsp_g) !== model[1] ||
          bus_a.rsp_err !== 1'b0 || bus_a.cmd_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall[%0d]: vld=%b g=%0d err=%b rdy=%b, required 1 %0d 0 0",
                 i, bus_a.rsp_valid, bus_a.rsp_g, bus_a.rsp_err, bus_a.cmd_ready, model[1]);
      end
      @(negedge clk);
    end
    bus_a.cmd_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    nvec++;
    if (bus_a.rsp_valid !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL idle_rsp_ready: vld=%b rdy=%b, required 0 1",
               bus_a.rsp_valid, bus_a.cmd_ready);
    end
    bus_a.rsp_ready = 1'b0;
    run_cmd(2, 0, 0);
    e = sb.pop_front();
    nvec++;
    if (obs_g !== e.g || obs_err !== 1'b0) begin
      nerr++;
      $display("FAIL stalled_cmd_ignored: cell2 g=%0d, required %0d", obs_g, e.g);
    end
  endtask

  task automatic test_reset_mid_apply();
    exp_t e;
    @(negedge clk);
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_addr   = 3'd3;
    bus_a.cmd_vin    = 8'd20;
    bus_a.cmd_pulses = 8'd50;
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    nvec++;
    if (busy_a !== 1'b1 || bus_a.rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_apply: busy=%b vld=%b, required 1 0", busy_a, bus_a.rsp_valid);
    end
    reset = 1'b1;
    #1;
    nvec++;
    if (bus_a.cmd_ready !== 1'b0 || bus_a.rsp_valid !== 1'b0 || bus_a.rsp_g !== 32'd0 ||
        bus_a.rsp_err !== 1'b0 || busy_a !== 1'b1) begin
      nerr++;
      $display("FAIL async_reset: rdy=%b vld=%b g=%0d err=%b busy=%b, required 0 0 0 0 1",
               bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_g, bus_a.rsp_err, busy_a);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) model[i] = 10000;
    for (int i = 0; i < 4; i++) begin
      run_cmd(i, 0, 0);
      e = sb.pop_front();
      nvec++;
      if (obs_g !== 64'd10000 || obs_err !== 1'b0) begin
        nerr++;
        $display("FAIL reinit[%0d]: g=%0d err=%b, required g=10000 err=0", i, obs_g, obs_err);
      end
    end
  endtask

`ifdef MEMRISTOR_WINDOW_EN
  task automatic test_window();
    exp_t e;
    run_cmd(0, 71, 10);
    e = sb.pop_front();
    nvec++;
    if (obs_g !== e.g || obs_g !== 64'd80000) begin
      nerr++;
      $display("FAIL window_ramp: g=%0d, required 80000", obs_g);
    end
    run_cmd(0, 11, 1);
    e = sb.pop_front();
    nvec++;
    if (obs_g !== e.g || obs_g !== 64'd80500) begin
      nerr++;
      $display("FAIL window_halved: g=%0d, required 80500", obs_g);
    end
  endtask
`endif

  initial begin
    reset            = 1'b1;
    bus_a.cmd_valid  = 1'b0;
    bus_a.cmd_addr   = '0;
    bus_a.cmd_vin    = '0;
    bus_a.cmd_pulses = '0;
    bus_a.rsp_ready  = 1'b0;
    bus_b.cmd_valid  = 1'b0;
    bus_b.cmd_addr   = '0;
    bus_b.cmd_vin    = '0;
    bus_b.cmd_pulses = '0;
    bus_b.rsp_ready  = 1'b0;
    test_reset();
    test_read();
    test_set_reset();
    test_saturation();
    test_addressing();
    test_mismatch();
    test_handshake();
    test_reset_mid_apply();
`ifdef MEMRISTOR_WINDOW_EN
    test_window();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
